// File: rtl/dispatch_credit_ctrl_pkg.sv
// rtl/dispatch_credit_ctrl_pkg.sv - shared types and defaults for the dispatch credit controller
package dispatch_credit_ctrl_pkg;

  localparam int RS_SIZE_DEF      = 16;
  localparam int LSB_SIZE_DEF     = 16;
  localparam int ROB_SIZE_DEF     = 16;
  localparam int CNT_W_DEF        = 5;
  localparam int FLUSH_CYCLES_DEF = 2;
  localparam int FLUSH_W          = 3;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  // Reload value for the flush hold counter (1..7 cycles fits FLUSH_W bits).
  function automatic logic [FLUSH_W-1:0] flush_load(input int cycles);
    return FLUSH_W'(cycles);
  endfunction

endpackage

// File: rtl/dispatch_credit_ctrl_credit_counter.sv
// rtl/dispatch_credit_ctrl_credit_counter.sv - saturating free-slot credit counter with sticky overflow flag
module dispatch_credit_ctrl_credit_counter #(
  parameter int SIZE  = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             en,
  input  logic             consume,
  input  logic             rel,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(SIZE);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  // Credit state: load beats consume/release; a release at full is dropped and flagged.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt <= FULL;
      err <= 1'b0;
    end else if (en) begin
      if (load) begin
        cnt <= load_val;
      end else if (consume && !rel) begin
        cnt <= cnt - ONE;
      end else if (rel && !consume) begin
        if (cnt == FULL) begin
          err <= 1'b1;
        end else begin
          cnt <= cnt + ONE;
        end
      end
    end
  end

endmodule

// File: rtl/dispatch_credit_ctrl.sv
// rtl/dispatch_credit_ctrl.sv - issue scheduler granting dispatch only when RS/LSB/ROB credits exist
module dispatch_credit_ctrl
  import dispatch_credit_ctrl_pkg::*;
#(
  parameter int RS_SIZE      = RS_SIZE_DEF,
  parameter int LSB_SIZE     = LSB_SIZE_DEF,
  parameter int ROB_SIZE     = ROB_SIZE_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear,
  input  logic [CNT_W-1:0] lsb_kept,
  input  logic             fetch_valid,
  input  logic             fetch_is_mem,
  input  logic             rs_release,
  input  logic             lsb_release,
  input  logic             rob_commit,
  output logic             issue_grant,
  output logic             fetch_stall,
  output logic [CNT_W-1:0] rs_free,
  output logic [CNT_W-1:0] lsb_free,
  output logic [CNT_W-1:0] rob_free,
  output logic             credit_err
);

  localparam logic [CNT_W-1:0]   RS_FULL    = CNT_W'(RS_SIZE);
  localparam logic [CNT_W-1:0]   LSB_FULL   = CNT_W'(LSB_SIZE);
  localparam logic [CNT_W-1:0]   ROB_FULL   = CNT_W'(ROB_SIZE);
  localparam logic [FLUSH_W-1:0] FLUSH_LOAD = flush_load(FLUSH_CYCLES);

  state_t             state;
  state_t             state_nxt;
  logic [FLUSH_W-1:0] flush_cnt;
  logic [FLUSH_W-1:0] flush_nxt;
  logic               in_run;
  logic               rs_err;
  logic               lsb_err;
  logic               rob_err;
  logic [CNT_W-1:0]   lsb_reload;

  assign in_run     = (state == S_RUN);
  assign lsb_reload = LSB_FULL - lsb_kept;

  // Grant depends only on registered credits, so a same-cycle release never enables it.
  assign issue_grant = rdy_in & ~rst_in & ~clear & in_run & fetch_valid
                     & (rob_free != '0)
                     & (fetch_is_mem ? (lsb_free != '0) : (rs_free != '0));
  assign fetch_stall = fetch_valid & ~issue_grant;
  assign credit_err  = rs_err | lsb_err | rob_err;

  // FSM and flush hold counter registers; rdy_in low freezes them.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= S_RUN;
      flush_cnt <= '0;
    end else if (rdy_in) begin
      state     <= state_nxt;
      flush_cnt <= flush_nxt;
    end
  end

  // Next state: clear (re)starts the flush hold; the hold counts down only while clear is low.
  always_comb begin
    state_nxt = state;
    flush_nxt = flush_cnt;
    if (clear) begin
      state_nxt = S_FLUSH;
      flush_nxt = FLUSH_LOAD;
    end else if (state == S_FLUSH) begin
      if (flush_cnt == FLUSH_W'(1)) begin
        state_nxt = S_RUN;
        flush_nxt = '0;
      end else begin
        flush_nxt = flush_cnt - FLUSH_W'(1);
      end
    end
  end

  dispatch_credit_ctrl_credit_counter #(.SIZE(RS_SIZE), .CNT_W(CNT_W)) u_rs_cnt (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .en       (rdy_in),
    .consume  (issue_grant & ~fetch_is_mem),
    .rel      (rs_release & in_run),
    .load     (clear),
    .load_val (RS_FULL),
    .cnt      (rs_free),
    .err      (rs_err)
  );

  // Kept stores keep draining during the flush, so LSB releases are not gated by state.
  dispatch_credit_ctrl_credit_counter #(.SIZE(LSB_SIZE), .CNT_W(CNT_W)) u_lsb_cnt (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .en       (rdy_in),
    .consume  (issue_grant & fetch_is_mem),
    .rel      (lsb_release),
    .load     (clear),
    .load_val (lsb_reload),
    .cnt      (lsb_free),
    .err      (lsb_err)
  );

  dispatch_credit_ctrl_credit_counter #(.SIZE(ROB_SIZE), .CNT_W(CNT_W)) u_rob_cnt (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .en       (rdy_in),
    .consume  (issue_grant),
    .rel      (rob_commit & in_run),
    .load     (clear),
    .load_val (ROB_FULL),
    .cnt      (rob_free),
    .err      (rob_err)
  );

endmodule

// File: tb/tb_dispatch_credit_ctrl.sv
// tb/tb_dispatch_credit_ctrl.sv - self-checking bench for dispatch_credit_ctrl
module tb_dispatch_credit_ctrl;

  typedef struct {
    logic       rst;
    logic       rdy;
    logic       clr;
    logic [4:0] kept;
    logic       fv;
    logic       mem;
    logic       rsr;
    logic       lsbr;
    logic       robc;
    logic       g;
    logic       st;
    logic [4:0] rs;
    logic [4:0] lsb;
    logic [4:0] rob;
    logic       err;
  } vec_t;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       rdy_in = 1'b1;
  logic       clear = 1'b0;
  logic [4:0] lsb_kept = '0;
  logic       fetch_valid = 1'b0;
  logic       fetch_is_mem = 1'b0;
  logic       rs_release = 1'b0;
  logic       lsb_release = 1'b0;
  logic       rob_commit = 1'b0;
  logic       issue_grant;
  logic       fetch_stall;
  logic [4:0] rs_free;
  logic [4:0] lsb_free;
  logic [4:0] rob_free;
  logic       credit_err;

  int   checks = 0;
  int   errors = 0;
  int   row = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  int   m_rs, m_lsb, m_rob, m_fc;
  bit   m_err, m_flush;

  dispatch_credit_ctrl dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .clear        (clear),
    .lsb_kept     (lsb_kept),
    .fetch_valid  (fetch_valid),
    .fetch_is_mem (fetch_is_mem),
    .rs_release   (rs_release),
    .lsb_release  (lsb_release),
    .rob_commit   (rob_commit),
    .issue_grant  (issue_grant),
    .fetch_stall  (fetch_stall),
    .rs_free      (rs_free),
    .lsb_free     (lsb_free),
    .rob_free     (rob_free),
    .credit_err   (credit_err)
  );

  always #5 clk_in = ~clk_in;

  function automatic vec_t mk(input logic rst, input logic rdy, input logic clr, input int kept,
                              input logic fv, input logic mem, input logic rsr, input logic lsbr,
                              input logic robc, input logic g, input logic st, input int rs,
                              input int lsb, input int rob, input logic err);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.clr = clr; v.kept = 5'(kept);
    v.fv = fv; v.mem = mem; v.rsr = rsr; v.lsbr = lsbr; v.robc = robc;
    v.g = g; v.st = st; v.rs = 5'(rs); v.lsb = 5'(lsb); v.rob = 5'(rob); v.err = err;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL row %0d %s: got %0d expected %0d", row, nm, act, exp);
    end
  endtask

  task automatic check_out();
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL row %0d scoreboard: got empty queue expected entry", row);
    end else begin
      e = exp_q.pop_front();
      cmp("issue_grant", {4'b0, issue_grant}, {4'b0, e.g});
      cmp("fetch_stall", {4'b0, fetch_stall}, {4'b0, e.st});
      cmp("rs_free", rs_free, e.rs);
      cmp("lsb_free", lsb_free, e.lsb);
      cmp("rob_free", rob_free, e.rob);
      cmp("credit_err", {4'b0, credit_err}, {4'b0, e.err});
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, check mid-cycle, then step past the edge.
  task automatic run_vec(input vec_t v);
    rst_in = v.rst; rdy_in = v.rdy; clear = v.clr; lsb_kept = v.kept;
    fetch_valid = v.fv; fetch_is_mem = v.mem;
    rs_release = v.rsr; lsb_release = v.lsbr; rob_commit = v.robc;
    exp_q.push_back(v);
    @(negedge clk_in);
    check_out();
    @(posedge clk_in);
    #1;
    row++;
  endtask

  function automatic logic model_grant(input vec_t v);
    return v.rdy && !v.rst && !v.clr && !m_flush && v.fv && m_rob != 0 &&
           (v.mem ? m_lsb != 0 : m_rs != 0);
  endfunction

  function automatic int bump(input int cur, input bit cons, input bit rel);
    if (cons && !rel) return cur - 1;
    if (rel && !cons) begin
      if (cur == 16) begin
        m_err = 1'b1;
        return cur;
      end
      return cur + 1;
    end
    return cur;
  endfunction

  task automatic model_step(input vec_t v);
    bit g;
    g = model_grant(v);
    if (v.rst) begin
      m_rs = 16; m_lsb = 16; m_rob = 16; m_err = 0; m_flush = 0; m_fc = 0;
    end else if (v.rdy) begin
      if (v.clr) begin
        m_rs = 16; m_rob = 16; m_lsb = 16 - int'(v.kept); m_flush = 1; m_fc = 2;
      end else if (!m_flush) begin
        m_rs  = bump(m_rs, g && !v.mem, v.rsr);
        m_rob = bump(m_rob, g, v.robc);
        m_lsb = bump(m_lsb, g && v.mem, v.lsbr);
      end else begin
        m_lsb = bump(m_lsb, 1'b0, v.lsbr);
        if (m_fc == 1) m_flush = 0;
        m_fc = m_fc - 1;
      end
    end
  endtask

  initial begin
    vec_t v;
    // Reset held across two sampled cycles.
    tbl.push_back(mk(1,1,0,0, 1,0,0,0,0, 0,1,16,16,16,0));
    tbl.push_back(mk(1,1,0,0, 1,0,0,0,0, 0,1,16,16,16,0));
    // 16 ALU grants drain RS and ROB; the 17th stalls.
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(0,1,0,0, 1,0,0,0,0, 1,0,16-i,16,16-i,0));
    tbl.push_back(mk(0,1,0,0, 1,0,0,0,0, 0,1,0,16,0,0));
    // Same-cycle release does not grant; the credit is usable next cycle.
    tbl.push_back(mk(0,1,0,0, 1,0,1,0,1, 0,1,0,16,0,0));
    tbl.push_back(mk(0,1,0,0, 1,0,0,0,0, 1,0,1,16,1,0));
    // Refill RS/ROB to 5, then grant with simultaneous RS release.
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0,1,0,0, 0,0,1,0,1, 0,0,k,16,k,0));
    tbl.push_back(mk(0,1,0,0, 1,0,1,0,0, 1,0,5,16,5,0));
    tbl.push_back(mk(0,1,0,0, 1,1,0,0,0, 1,0,5,16,4,0));
    // Clear with 3 kept stores, two blocked flush cycles, grant on the third.
    tbl.push_back(mk(0,1,1,3, 1,0,0,0,0, 0,1,5,15,3,0));
    tbl.push_back(mk(0,1,0,0, 1,0,1,1,1, 0,1,16,13,16,0));
    tbl.push_back(mk(0,1,0,0, 1,0,0,0,0, 0,1,16,14,16,0));
    tbl.push_back(mk(0,1,0,0, 1,0,0,0,0, 1,0,16,14,16,0));
    // rdy_in low freezes everything and drops releases.
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0,0,0,0, 1,0,1,1,1, 0,1,15,14,15,0));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0,0, 0,0,15,14,15,0));
    tbl.push_back(mk(0,1,0,0, 0,0,1,0,1, 0,0,15,14,15,0));
    // Release at full sets the sticky error.
    tbl.push_back(mk(0,1,0,0, 0,0,1,0,0, 0,0,16,14,16,0));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0,0, 0,0,16,14,16,1));
    // Clear re-asserted during the flush reloads counters and the hold.
    tbl.push_back(mk(0,1,1,0, 1,0,0,0,0, 0,1,16,14,16,1));
    tbl.push_back(mk(0,1,1,5, 1,0,0,0,0, 0,1,16,16,16,1));
    tbl.push_back(mk(0,1,0,0, 1,1,0,0,0, 0,1,16,11,16,1));
    tbl.push_back(mk(0,1,0,0, 1,1,0,0,0, 0,1,16,11,16,1));
    tbl.push_back(mk(0,1,0,0, 1,1,0,0,0, 1,0,16,11,16,1));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0,0, 0,0,16,10,15,1));
    // rdy_in low during the flush holds the hold counter.
    tbl.push_back(mk(0,1,1,0, 1,0,0,0,0, 0,1,16,10,15,1));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0,0,0,0, 1,0,0,0,0, 0,1,16,16,16,1));
    tbl.push_back(mk(0,1,0,0, 1,0,0,0,0, 0,1,16,16,16,1));
    tbl.push_back(mk(0,1,0,0, 1,0,0,0,0, 0,1,16,16,16,1));
    tbl.push_back(mk(0,1,0,0, 1,0,0,0,0, 1,0,16,16,16,1));
    // Reset in the middle of a flush returns to RUN with full credits.
    tbl.push_back(mk(0,1,1,7, 1,0,0,0,0, 0,1,15,16,15,1));
    tbl.push_back(mk(1,1,0,0, 1,0,0,0,0, 0,1,16,9,16,1));
    tbl.push_back(mk(0,1,0,0, 1,0,0,0,0, 1,0,16,16,16,0));
    tbl.push_back(mk(1,1,0,0, 0,0,0,0,0, 0,0,15,16,15,0));

    @(posedge clk_in);
    #1;
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

    // Randomised traffic against the reference model.
    m_rs = 16; m_lsb = 16; m_rob = 16; m_err = 0; m_flush = 0; m_fc = 0;
    for (int i = 0; i < 400; i++) begin
      v.rst  = ($urandom_range(0, 99) == 0);
      v.rdy  = ($urandom_range(0, 9) != 0);
      v.clr  = ($urandom_range(0, 19) == 0);
      v.kept = 5'($urandom_range(0, 8));
      v.fv   = ($urandom_range(0, 3) != 0);
      v.mem  = 1'($urandom_range(0, 1));
      v.rsr  = ($urandom_range(0, 2) == 0);
      v.lsbr = ($urandom_range(0, 2) == 0);
      v.robc = ($urandom_range(0, 2) == 0);
      v.g    = model_grant(v);
      v.st   = v.fv && !v.g;
      v.rs   = 5'(m_rs);
      v.lsb  = 5'(m_lsb);
      v.rob  = 5'(m_rob);
      v.err  = m_err;
      run_vec(v);
      model_step(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
